// File: rtl/dem_switch_tree.sv
// dem_switch_tree: tree-structured dynamic element matching encoder for a unit-element DAC.
// A clamped input count is split through N_LAYERS layers of 2-way switching nodes into
// 2**N_LAYERS one-bit unit-element enables. There is one register stage per layer.
// Odd node inputs are steered in one of three ways: static, LFSR pseudo-random, or
// first-order noise-shaped using a toggle bit per node.
// Ports:
//   clk_i    - clock, rising edge
//   reset_i  - synchronous active-high reset
//   valid_i  - x_in_i / mode_i carry a sample this cycle
//   x_in_i   - unit-element count, 0..2**N_LAYERS; larger values are clamped
//   mode_i   - 0 static, 1 random, 2 noise-shaped, 3 same as static
//   valid_o  - unit_o carries a sample this cycle
//   unit_o   - element enables, bit i = leaf i
//   ovf_o    - the sample on unit_o was clamped
module dem_switch_tree #(
    parameter int unsigned N_LAYERS  = 3,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     valid_i,
    input  logic [N_LAYERS:0]        x_in_i,
    input  logic [1:0]               mode_i,
    output logic                     valid_o,
    output logic [(2**N_LAYERS)-1:0] unit_o,
    output logic                     ovf_o
);

    localparam int unsigned Leaves    = 2 ** N_LAYERS;
    localparam int unsigned Cw        = N_LAYERS + 1;
    localparam int unsigned Nodes     = Leaves - 1;
    localparam int unsigned MetaDepth = (N_LAYERS > 1) ? N_LAYERS - 1 : 1;

    typedef logic [Cw-1:0] cnt_t;
    typedef cnt_t cnt_row_t [Leaves];

    logic [15:0]      lfsr_q;
    logic [15:0]      lfsr_next;
    logic [Nodes-1:0] tog_q;
    logic [Nodes-1:0] tog_d;

    // Stage k holds the outputs of layer k. Mode and the latched LFSR value are not needed
    // after the last layer, so they are kept for the first N_LAYERS-1 stages only.
    logic        vld_q   [1:N_LAYERS];
    logic        ovf_q   [1:N_LAYERS];
    cnt_row_t    cnt_q   [1:N_LAYERS];
    cnt_row_t    cnt_d   [1:N_LAYERS];
    logic [1:0]  mode_q  [1:MetaDepth];
    logic [15:0] lfsr_sq [1:MetaDepth];

    // Inputs of layer k+1. Index 0 is the unregistered input sample.
    cnt_row_t    lx [N_LAYERS];
    logic        lv [N_LAYERS];
    logic        lo [N_LAYERS];
    logic [1:0]  lm [N_LAYERS];
    logic [15:0] lr [N_LAYERS];

    logic ovf_in;
    cnt_t x_clamp;

    // Galois LFSR for x^16+x^14+x^13+x^11+1 in its right-shifting form.
    assign lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

    // Bubbles enter the tree as a zero count, so they never touch a toggle and reach the
    // output with all enables low.
    always_comb begin
        ovf_in  = valid_i && (x_in_i > cnt_t'(Leaves));
        x_clamp = '0;
        if (valid_i) begin
            x_clamp = ovf_in ? cnt_t'(Leaves) : x_in_i;
        end
    end

    always_comb begin
        int   node;
        cnt_t xv;
        cnt_t half;
        cnt_t half_up;
        cnt_t top;
        cnt_t bot;
        logic up;

        node    = 0;
        xv      = '0;
        half    = '0;
        half_up = '0;
        top     = '0;
        bot     = '0;
        up      = 1'b1;
        tog_d   = tog_q;

        for (int k = 0; k < N_LAYERS; k++) begin
            for (int j = 0; j < Leaves; j++) begin
                lx[k][j] = '0;
            end
        end
        lx[0][0] = x_clamp;
        lv[0]    = valid_i;
        lo[0]    = ovf_in;
        lm[0]    = mode_i;
        lr[0]    = lfsr_q;
        for (int k = 1; k < N_LAYERS; k++) begin
            lx[k] = cnt_q[k];
            lv[k] = vld_q[k];
            lo[k] = ovf_q[k];
            lm[k] = mode_q[k];
            lr[k] = lfsr_sq[k];
        end

        for (int k = 1; k <= N_LAYERS; k++) begin
            for (int j = 0; j < Leaves; j++) begin
                cnt_d[k][j] = '0;
            end
        end

        for (int k = 0; k < N_LAYERS; k++) begin
            for (int j = 0; j < (1 << k); j++) begin
                node    = (1 << k) - 1 + j;
                xv      = lx[k][j];
                half    = xv >> 1;
                half_up = (xv + cnt_t'(1)) >> 1;
                case (lm[k])
                    2'd1:    up = lr[k][node % 16];
                    2'd2: begin
                        up = ~tog_q[node];
                        if (lv[k] && xv[0]) begin
                            tog_d[node] = ~tog_q[node];
                        end
                    end
                    default: up = 1'b1;
                endcase
                // Even counts split evenly; an odd count sends the extra unit up or down.
                if (!xv[0]) begin
                    top = half;
                    bot = half;
                end else if (up) begin
                    top = half_up;
                    bot = half;
                end else begin
                    top = half;
                    bot = half_up;
                end
                cnt_d[k+1][2*j]   = top;
                cnt_d[k+1][2*j+1] = bot;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            lfsr_q <= LFSR_SEED;
            tog_q  <= '0;
            for (int k = 1; k <= N_LAYERS; k++) begin
                vld_q[k] <= 1'b0;
                ovf_q[k] <= 1'b0;
                for (int j = 0; j < Leaves; j++) begin
                    cnt_q[k][j] <= '0;
                end
            end
            for (int k = 1; k <= MetaDepth; k++) begin
                mode_q[k]  <= '0;
                lfsr_sq[k] <= '0;
            end
        end else begin
            tog_q <= tog_d;
            if (valid_i) begin
                lfsr_q <= lfsr_next;
            end
            for (int k = 1; k <= N_LAYERS; k++) begin
                vld_q[k] <= lv[k-1];
                ovf_q[k] <= lo[k-1];
                cnt_q[k] <= cnt_d[k];
            end
            for (int k = 1; k <= MetaDepth; k++) begin
                mode_q[k]  <= lm[k-1];
                lfsr_sq[k] <= lr[k-1];
            end
        end
    end

    // Leaf counts are 0 or 1 by construction.
    always_comb begin
        for (int i = 0; i < Leaves; i++) begin
            unit_o[i] = |cnt_q[N_LAYERS][i];
        end
    end

    assign valid_o = vld_q[N_LAYERS];
    assign ovf_o   = ovf_q[N_LAYERS];

endmodule

// File: tb/tb_dem_switch_tree.sv
// tb_dem_switch_tree: self-checking bench for dem_switch_tree (N_LAYERS = 3).
// The reference model splits each accepted sample recursively with signed selectors
// and integer arithmetic, keeping its own node toggles and LFSR.
module tb_dem_switch_tree;

    localparam int N = 3;
    localparam int L = 8;

    logic         clk = 1'b0;
    logic         reset_i = 1'b1;
    logic         valid_i = 1'b0;
    logic [N:0]   x_in_i = '0;
    logic [1:0]   mode_i = '0;
    logic         valid_o;
    logic [L-1:0] unit_o;
    logic         ovf_o;

    always #5 clk = ~clk;

    dem_switch_tree #(
        .N_LAYERS  (N),
        .LFSR_SEED (16'hACE1)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .valid_i (valid_i),
        .x_in_i  (x_in_i),
        .mode_i  (mode_i),
        .valid_o (valid_o),
        .unit_o  (unit_o),
        .ovf_o   (ovf_o)
    );

    typedef struct {
        logic [L-1:0] unit;
        logic         ovf;
        int           x;
        int           due;
    } exp_t;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          m_tog [L];
    int unsigned m_lfsr;
    exp_t        exp_q [$];

    function automatic void model_reset();
        for (int i = 0; i < L; i++) m_tog[i] = 0;
        m_lfsr = 32'h0000ACE1;
    endfunction

    function automatic exp_t model_sample(input int x, input int m);
        int   cur [L];
        int   nxt [L];
        int   s;
        int   node;
        exp_t e;
        for (int i = 0; i < L; i++) cur[i] = 0;
        e.ovf  = (x > L);
        cur[0] = (x > L) ? L : x;
        e.x    = cur[0];
        for (int k = 1; k <= N; k++) begin
            for (int i = 0; i < L; i++) nxt[i] = 0;
            for (int j = 0; j < (1 << (k - 1)); j++) begin
                node = (1 << (k - 1)) - 1 + j;
                if (cur[j] % 2 == 0) s = 0;
                else if (m == 1) s = ((m_lfsr >> (node % 16)) & 1) != 0 ? 1 : -1;
                else if (m == 2) begin
                    s = (m_tog[node] != 0) ? -1 : 1;
                    m_tog[node] = 1 - m_tog[node];
                end else s = 1;
                nxt[2*j]   = (cur[j] + s) / 2;
                nxt[2*j+1] = (cur[j] - s) / 2;
            end
            cur = nxt;
        end
        for (int i = 0; i < L; i++) e.unit[i] = (cur[i] != 0);
        if ((m_lfsr & 1) != 0) m_lfsr = (m_lfsr >> 1) ^ 32'h0000B400;
        else m_lfsr = m_lfsr >> 1;
        e.due = 0;
        return e;
    endfunction

    // One clock: drive at the falling edge, let the rising edge sample, return at the
    // next falling edge so outputs are read away from the active edge.
    task automatic step(input logic v, input int x, input int m);
        exp_t e;
        valid_i = v;
        x_in_i  = x[N:0];
        mode_i  = m[1:0];
        @(posedge clk);
        cyc++;
        if (v && !reset_i) begin
            e     = model_sample(x, m);
            e.due = cyc + N - 1;
            exp_q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        reset_i = 1'b1;
        repeat (n) step(1'b0, 0, 0);
        reset_i = 1'b0;
        model_reset();
        exp_q.delete();
    endtask

    task automatic test_reset();
        exp_t e;
        reset_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 5, 0);
            n_cmp++;
            if (valid_o !== 1'b0 || unit_o !== '0) begin
                n_err++;
                $display("FAIL reset_hold: valid_o=%b unit_o=%h, required 0/00", valid_o, unit_o);
            end
        end
        reset_i = 1'b0;
        model_reset();
        exp_q.delete();
        step(1'b1, 5, 0);
        for (int i = 1; i < N; i++) begin
            n_cmp++;
            if (valid_o !== 1'b0) begin
                n_err++;
                $display("FAIL reset_latency_early: cycle %0d valid_o=%b, required 0", i, valid_o);
            end
            step(1'b0, 0, 0);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (valid_o !== 1'b1 || unit_o !== 8'h57 || unit_o !== e.unit) begin
            n_err++;
            $display("FAIL reset_first_out: valid_o=%b unit_o=%h, required 1/57 (model %h)",
                     valid_o, unit_o, e.unit);
        end
    endtask

    task automatic test_static();
        exp_t e;
        do_reset(2);
        step(1'b1, 5, 0);
        step(1'b0, 0, 0);
        step(1'b0, 0, 0);
        e = exp_q.pop_front();
        n_cmp++;
        if (valid_o !== 1'b1 || unit_o !== 8'h57 || ovf_o !== 1'b0 || unit_o !== e.unit) begin
            n_err++;
            $display("FAIL static_x5: valid_o=%b unit_o=%h ovf_o=%b, required 1/57/0",
                     valid_o, unit_o, ovf_o);
        end
        step(1'b0, 0, 0);
        n_cmp++;
        if (valid_o !== 1'b0 || unit_o !== '0 || ovf_o !== 1'b0) begin
            n_err++;
            $display("FAIL static_bubble: valid_o=%b unit_o=%h ovf_o=%b, required 0/00/0",
                     valid_o, unit_o, ovf_o);
        end
    endtask

    task automatic test_noise_shaped();
        int           order [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
        logic [L-1:0] want;
        int           idx;
        do_reset(2);
        for (int i = 0; i < 16 + N - 1; i++) begin
            step(i < 16, 1, 2);
            if (i >= N - 1) begin
                idx  = i - (N - 1);
                want = '0;
                want[order[idx % 8]] = 1'b1;
                void'(exp_q.pop_front());
                n_cmp++;
                if (valid_o !== 1'b1 || unit_o !== want) begin
                    n_err++;
                    $display("FAIL noise_order[%0d]: valid_o=%b unit_o=%h, required 1/%h",
                             idx, valid_o, unit_o, want);
                end
            end
        end
    endtask

    task automatic test_overflow();
        do_reset(2);
        step(1'b1, 12, 0);
        step(1'b1, 8, 0);
        step(1'b0, 0, 0);
        n_cmp++;
        if (valid_o !== 1'b1 || unit_o !== 8'hFF || ovf_o !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_clamp: valid_o=%b unit_o=%h ovf_o=%b, required 1/ff/1",
                     valid_o, unit_o, ovf_o);
        end
        step(1'b0, 0, 0);
        n_cmp++;
        if (valid_o !== 1'b1 || unit_o !== 8'hFF || ovf_o !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_full_scale: valid_o=%b unit_o=%h ovf_o=%b, required 1/ff/0",
                     valid_o, unit_o, ovf_o);
        end
        step(1'b0, 0, 0);
        n_cmp++;
        if (valid_o !== 1'b0 || ovf_o !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_after: valid_o=%b ovf_o=%b, required 0/0", valid_o, ovf_o);
        end
        exp_q.delete();
    endtask

    task automatic test_random();
        exp_t e;
        int   accepted = 0;
        logic v;
        do_reset(2);
        for (int c = 0; c < 8000 && (accepted < 1000 || exp_q.size() > 0); c++) begin
            v = (accepted < 1000) && ($urandom_range(0, 3) != 0);
            step(v, $urandom_range(0, 8), $urandom_range(0, 3));
            if (v) accepted++;
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (valid_o !== 1'b1 || unit_o !== e.unit || ovf_o !== e.ovf) begin
                    n_err++;
                    $display("FAIL random_out: cyc %0d valid_o=%b unit_o=%h ovf_o=%b, required 1/%h/%b",
                             cyc, valid_o, unit_o, ovf_o, e.unit, e.ovf);
                end
                n_cmp++;
                if ($countones(unit_o) != e.x) begin
                    n_err++;
                    $display("FAIL random_popcount: cyc %0d popcount=%0d, required %0d",
                             cyc, $countones(unit_o), e.x);
                end
            end else begin
                n_cmp++;
                if (valid_o !== 1'b0 || unit_o !== '0 || ovf_o !== 1'b0) begin
                    n_err++;
                    $display("FAIL random_gap: cyc %0d valid_o=%b unit_o=%h, required 0/00",
                             cyc, valid_o, unit_o);
                end
            end
        end
        n_cmp++;
        if (accepted < 1000 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL random_budget: accepted=%0d pending=%0d, required 1000/0",
                     accepted, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_stream();
        do_reset(2);
        for (int i = 0; i < 5; i++) step(1'b1, 1, 2);
        reset_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 0, 0);
            n_cmp++;
            if (valid_o !== 1'b0) begin
                n_err++;
                $display("FAIL midreset_hold: valid_o=%b, required 0", valid_o);
            end
        end
        reset_i = 1'b0;
        model_reset();
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            step(1'b0, 0, 0);
            n_cmp++;
            if (valid_o !== 1'b0 || unit_o !== '0) begin
                n_err++;
                $display("FAIL midreset_discard: valid_o=%b unit_o=%h, required 0/00",
                         valid_o, unit_o);
            end
        end
        step(1'b1, 1, 2);
        step(1'b0, 0, 0);
        step(1'b0, 0, 0);
        n_cmp++;
        if (valid_o !== 1'b1 || unit_o !== 8'h01) begin
            n_err++;
            $display("FAIL midreset_toggle_restart: valid_o=%b unit_o=%h, required 1/01",
                     valid_o, unit_o);
        end
        exp_q.delete();
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_static();
        test_noise_shaped();
        test_overflow();
        test_random();
        test_reset_mid_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
